// File: rtl/gs_pkg.sv
// gs_pkg: shared types and constants for the hazard controller slice.
//   gs_hz_state_e  : hazard FSM state encoding (RUN/LOAD_STALL/MEM_WAIT/REDIRECT)
//   REG_*_FORWARD  : operand source select encodings used by gs_fwd_sel
//   GS_CNT_W       : width of the stall/flush down-counter
package gs_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    REDIRECT   = 2'd3
  } gs_hz_state_e;

  localparam logic [1:0] REG_NO_FORWARD = 2'd0;
  localparam logic [1:0] REG_EX_FORWARD = 2'd1;
  localparam logic [1:0] REG_WB_FORWARD = 2'd2;

  localparam int GS_CNT_W = 3;

endpackage

// File: rtl/gs_fwd_sel.sv
// gs_fwd_sel: operand forwarding select for one source register.
// Ports:
//   rs_addr_i        (in, 5)  source register address read in ID
//   ex_reg_write_i   (in, 1)  EX stage writes a register
//   ex_mem_read_i    (in, 1)  EX stage is a load (result not yet available)
//   ex_rd_addr_i     (in, 5)  EX destination register
//   wb_reg_write_i   (in, 1)  WB/LSU stage writes a register
//   wb_rd_addr_i     (in, 5)  WB destination register
//   kill_i           (in, 1)  force no forwarding (pipeline being flushed)
//   sel_o            (out, 2) REG_NO_FORWARD / REG_EX_FORWARD / REG_WB_FORWARD
module gs_fwd_sel
  import gs_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic       ex_reg_write_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       wb_reg_write_i,
  input  logic [4:0] wb_rd_addr_i,
  input  logic       kill_i,
  output logic [1:0] sel_o
);

  // Priority select: x0 never forwards, the younger EX result beats WB,
  // and a load in EX cannot forward because its data is not ready yet.
  always_comb begin
    sel_o = REG_NO_FORWARD;
    if (kill_i || (rs_addr_i == 5'd0)) begin
      sel_o = REG_NO_FORWARD;
    end else if (ex_reg_write_i && (ex_rd_addr_i == rs_addr_i) && !ex_mem_read_i) begin
      sel_o = REG_EX_FORWARD;
    end else if (wb_reg_write_i && (wb_rd_addr_i == rs_addr_i)) begin
      sel_o = REG_WB_FORWARD;
    end else begin
      sel_o = REG_NO_FORWARD;
    end
  end

endmodule

// File: rtl/gs_hazard_ctrl.sv
// gs_hazard_ctrl: pipeline hazard controller (stall / flush / forwarding).
// Optional build macro: GS_HAZARD_PERF_EN adds stall_cnt_o and flush_cnt_o.
// Parameters:
//   FLUSH_CYCLES (1..7) cycles ID/EX are flushed after a redirect
//   LOAD_BUBBLES (1..3) stall cycles inserted for a load-use hazard
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_valid_i, id_rs1/rs2_addr_i    ID stage instruction and sources
//   ex_RegWrite_i, ex_MemRead_i,
//   ex_rd_addr_i                     EX stage destination info
//   wb_RegWrite_i, wb_rd_addr_i      WB/LSU destination info
//   ex_redirect_i                    taken branch/jump resolved in EX
//   lsu_busy_i, lsu_done_i           LSU outstanding / completion pulse
//   halt_if_o, halt_id_o,
//   flush_id_o, flush_ex_o           pipeline control, decoded from state only
//   rs1/rs2_forward_sel_o            operand source selects
//   state_o                          current FSM state
//   stall_cnt_o, flush_cnt_o         (GS_HAZARD_PERF_EN only) saturating counters
module gs_hazard_ctrl
  import gs_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        ex_RegWrite_i,
  input  logic        ex_MemRead_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        wb_RegWrite_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic        ex_redirect_i,
  input  logic        lsu_busy_i,
  input  logic        lsu_done_i,
  output logic        halt_if_o,
  output logic        halt_id_o,
  output logic        flush_id_o,
  output logic        flush_ex_o,
  output logic [1:0]  rs1_forward_sel_o,
  output logic [1:0]  rs2_forward_sel_o,
  output logic [1:0]  state_o
`ifdef GS_HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  // Counter preloads: the count runs down to 0 inclusive, so N cycles load N-1.
  localparam logic [GS_CNT_W-1:0] FLUSH_LOAD  = GS_CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [GS_CNT_W-1:0] BUBBLE_LOAD = GS_CNT_W'(LOAD_BUBBLES - 1);

  gs_hz_state_e        state_q, state_d;
  logic [GS_CNT_W-1:0] cnt_q, cnt_d;
  logic                load_use_s;
  logic                mem_exit_s;
  logic                busy_s;
  logic                fwd_kill_s;

  assign load_use_s = id_valid_i && ex_MemRead_i && (ex_rd_addr_i != 5'd0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

  // A completion pulse in MEM_WAIT releases the stall even if busy is still
  // sampled high in the same cycle (busy may lag done by a cycle).
  assign mem_exit_s = (state_q == MEM_WAIT) && lsu_done_i;
  assign busy_s     = lsu_busy_i && !mem_exit_s;

  // State and counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= {GS_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: redirect > LSU busy > load-use (RUN only) > per-state rule.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ex_redirect_i) begin
      // Also restarts the count when already in REDIRECT.
      state_d = REDIRECT;
      cnt_d   = FLUSH_LOAD;
    end else if (busy_s) begin
      state_d = MEM_WAIT;
      cnt_d   = {GS_CNT_W{1'b0}};
    end else if ((state_q == RUN) && load_use_s) begin
      state_d = LOAD_STALL;
      cnt_d   = BUBBLE_LOAD;
    end else begin
      case (state_q)
        RUN: begin
          state_d = RUN;
          cnt_d   = {GS_CNT_W{1'b0}};
        end
        LOAD_STALL, REDIRECT: begin
          if (cnt_q == {GS_CNT_W{1'b0}}) begin
            state_d = RUN;
            cnt_d   = {GS_CNT_W{1'b0}};
          end else begin
            state_d = state_q;
            cnt_d   = cnt_q - GS_CNT_W'(1);
          end
        end
        MEM_WAIT: begin
          state_d = RUN;
          cnt_d   = {GS_CNT_W{1'b0}};
        end
        default: begin
          state_d = RUN;
          cnt_d   = {GS_CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode from the registered state only: no input reaches halt/flush.
  always_comb begin
    halt_if_o  = 1'b0;
    halt_id_o  = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    case (state_q)
      RUN: begin
        halt_if_o  = 1'b0;
        halt_id_o  = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
      end
      LOAD_STALL: begin
        halt_if_o  = 1'b1;
        halt_id_o  = 1'b1;
        flush_ex_o = 1'b1;
      end
      MEM_WAIT: begin
        halt_if_o  = 1'b1;
        halt_id_o  = 1'b1;
      end
      REDIRECT: begin
        flush_id_o = 1'b1;
        flush_ex_o = 1'b1;
      end
      default: begin
        halt_if_o  = 1'b0;
        halt_id_o  = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
      end
    endcase
  end

  assign state_o    = state_q;
  assign fwd_kill_s = (state_q == REDIRECT);

  gs_fwd_sel u_fwd_rs1 (
    .rs_addr_i      (id_rs1_addr_i),
    .ex_reg_write_i (ex_RegWrite_i),
    .ex_mem_read_i  (ex_MemRead_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .wb_reg_write_i (wb_RegWrite_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .kill_i         (fwd_kill_s),
    .sel_o          (rs1_forward_sel_o)
  );

  gs_fwd_sel u_fwd_rs2 (
    .rs_addr_i      (id_rs2_addr_i),
    .ex_reg_write_i (ex_RegWrite_i),
    .ex_mem_read_i  (ex_MemRead_i),
    .ex_rd_addr_i   (ex_rd_addr_i),
    .wb_reg_write_i (wb_RegWrite_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .kill_i         (fwd_kill_s),
    .sel_o          (rs2_forward_sel_o)
  );

`ifdef GS_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating performance counters: stall cycles and accepted redirects.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (((state_q == LOAD_STALL) || (state_q == MEM_WAIT)) &&
          (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (ex_redirect_i && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_gs_hazard_ctrl.sv
// tb_gs_hazard_ctrl: table-driven bench for gs_hazard_ctrl (default parameters).
// Each vector holds one cycle of inputs and the outputs expected in that cycle
// (state is what earlier cycles left behind). Vectors are pushed to a queue when
// driven and popped and compared by a separate checker process.
module tb_gs_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       exrw;
    logic       exmr;
    logic [4:0] exrd;
    logic       wbrw;
    logic [4:0] wbrd;
    logic       redir;
    logic       busy;
    logic       done;
    logic [1:0] st;
    logic [3:0] hf;   // {halt_if, halt_id, flush_id, flush_ex}
    logic [1:0] f1;
    logic [1:0] f2;
  } vec_t;

  localparam logic [3:0] H0 = 4'b0000;
  localparam logic [3:0] LS = 4'b1101;
  localparam logic [3:0] MW = 4'b1100;
  localparam logic [3:0] RD = 4'b0011;

  logic       clk;
  logic       rst;
  logic       id_valid_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i;
  logic       ex_RegWrite_i, ex_MemRead_i;
  logic [4:0] ex_rd_addr_i;
  logic       wb_RegWrite_i;
  logic [4:0] wb_rd_addr_i;
  logic       ex_redirect_i, lsu_busy_i, lsu_done_i;
  logic       halt_if_o, halt_id_o, flush_id_o, flush_ex_o;
  logic [1:0] rs1_forward_sel_o, rs2_forward_sel_o, state_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_vec    = 0;
  vec_t sb[$];
  vec_t tbl[$];
  vec_t e;

  gs_hazard_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .id_valid_i        (id_valid_i),
    .id_rs1_addr_i     (id_rs1_addr_i),
    .id_rs2_addr_i     (id_rs2_addr_i),
    .ex_RegWrite_i     (ex_RegWrite_i),
    .ex_MemRead_i      (ex_MemRead_i),
    .ex_rd_addr_i      (ex_rd_addr_i),
    .wb_RegWrite_i     (wb_RegWrite_i),
    .wb_rd_addr_i      (wb_rd_addr_i),
    .ex_redirect_i     (ex_redirect_i),
    .lsu_busy_i        (lsu_busy_i),
    .lsu_done_i        (lsu_done_i),
    .halt_if_o         (halt_if_o),
    .halt_id_o         (halt_id_o),
    .flush_id_o        (flush_id_o),
    .flush_ex_o        (flush_ex_o),
    .rs1_forward_sel_o (rs1_forward_sel_o),
    .rs2_forward_sel_o (rs2_forward_sel_o),
    .state_o           (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic iv, input logic [4:0] a1, input logic [4:0] a2,
    input logic erw, input logic emr, input logic [4:0] erd,
    input logic wrw, input logic [4:0] wrd,
    input logic rdr, input logic bsy, input logic dn,
    input logic [1:0] st, input logic [3:0] hf, input logic [1:0] f1, input logic [1:0] f2);
    vec_t v;
    v.rst = r; v.idv = iv; v.rs1 = a1; v.rs2 = a2;
    v.exrw = erw; v.exmr = emr; v.exrd = erd; v.wbrw = wrw; v.wbrd = wrd;
    v.redir = rdr; v.busy = bsy; v.done = dn;
    v.st = st; v.hf = hf; v.f1 = f1; v.f2 = f2;
    return v;
  endfunction

  // Idle-input vector expecting the given state / control pattern.
  function automatic vec_t idle(input logic r, input logic rdr, input logic bsy,
                                input logic [1:0] st, input logic [3:0] hf);
    return mk(r, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, rdr, bsy, 1'b0, st, hf, 2'd0, 2'd0);
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    id_valid_i    = v.idv;
    id_rs1_addr_i = v.rs1;
    id_rs2_addr_i = v.rs2;
    ex_RegWrite_i = v.exrw;
    ex_MemRead_i  = v.exmr;
    ex_rd_addr_i  = v.exrd;
    wb_RegWrite_i = v.wbrw;
    wb_rd_addr_i  = v.wbrd;
    ex_redirect_i = v.redir;
    lsu_busy_i    = v.busy;
    lsu_done_i    = v.done;
    sb.push_back(v);
  endtask

  task automatic check(input string nm, input int idx, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %b expected %b", idx, nm, got, exp);
    end
  endtask

  // Checker: pops the expectation for this cycle, samples 2 time units after
  // the falling edge (well away from the rising edge).
  always @(negedge clk) begin
    #2;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("state", n_vec, {2'b00, state_o}, {2'b00, e.st});
      check("ctrl",  n_vec, {halt_if_o, halt_id_o, flush_id_o, flush_ex_o}, e.hf);
      check("fwd1",  n_vec, {2'b00, rs1_forward_sel_o}, {2'b00, e.f1});
      check("fwd2",  n_vec, {2'b00, rs2_forward_sel_o}, {2'b00, e.f2});
      n_vec++;
    end
  end

  initial begin
    rst = 1'b1; id_valid_i = 1'b0; id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
    ex_RegWrite_i = 1'b0; ex_MemRead_i = 1'b0; ex_rd_addr_i = 5'd0;
    wb_RegWrite_i = 1'b0; wb_rd_addr_i = 5'd0; ex_redirect_i = 1'b0;
    lsu_busy_i = 1'b0; lsu_done_i = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    tbl.push_back(idle(1'b1, 1'b0, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Forwarding: EX over WB, x0, load in EX, WB only
    tbl.push_back(mk(0, 0, 5'd7, 5'd7, 1, 0, 5'd7, 1, 5'd7, 0, 0, 0, 2'd0, H0, 2'd1, 2'd1));
    tbl.push_back(mk(0, 0, 5'd0, 5'd7, 1, 0, 5'd7, 1, 5'd7, 0, 0, 0, 2'd0, H0, 2'd0, 2'd1));
    tbl.push_back(mk(0, 0, 5'd7, 5'd3, 0, 0, 5'd7, 1, 5'd7, 0, 0, 0, 2'd0, H0, 2'd2, 2'd0));
    tbl.push_back(mk(0, 0, 5'd9, 5'd9, 1, 1, 5'd9, 1, 5'd9, 0, 0, 0, 2'd0, H0, 2'd2, 2'd2));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 5'd0, 0, 0, 0, 2'd0, H0, 2'd0, 2'd0));
    // lw x5 in EX, add x6,x5,x1 in ID -> one stall, then WB forward
    tbl.push_back(mk(0, 1, 5'd5, 5'd1, 1, 1, 5'd5, 0, 5'd0, 0, 0, 0, 2'd0, H0, 2'd0, 2'd0));
    tbl.push_back(mk(0, 1, 5'd5, 5'd1, 0, 0, 5'd0, 1, 5'd5, 0, 0, 0, 2'd1, LS, 2'd2, 2'd0));
    tbl.push_back(mk(0, 1, 5'd5, 5'd1, 0, 0, 5'd0, 1, 5'd5, 0, 0, 0, 2'd0, H0, 2'd2, 2'd0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Redirect pulse -> two flush cycles, forwarding killed meanwhile
    tbl.push_back(idle(1'b0, 1'b1, 1'b0, 2'd0, H0));
    tbl.push_back(mk(0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 0, 5'd0, 0, 0, 0, 2'd3, RD, 2'd0, 2'd0));
    tbl.push_back(mk(0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 0, 5'd0, 0, 0, 0, 2'd3, RD, 2'd0, 2'd0));
    tbl.push_back(mk(0, 0, 5'd7, 5'd0, 1, 0, 5'd7, 0, 5'd0, 0, 0, 0, 2'd0, H0, 2'd1, 2'd0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // LSU busy 5 cycles then done -> 5 halt cycles
    tbl.push_back(idle(1'b0, 1'b0, 1'b1, 2'd0, H0));
    for (int i = 0; i < 4; i++) tbl.push_back(idle(1'b0, 1'b0, 1'b1, 2'd2, MW));
    tbl.push_back(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 1, 2'd2, MW, 2'd0, 2'd0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Redirect together with load-use -> REDIRECT, never LOAD_STALL
    tbl.push_back(mk(0, 1, 5'd5, 5'd0, 1, 1, 5'd5, 0, 5'd0, 1, 0, 0, 2'd0, H0, 2'd0, 2'd0));
    tbl.push_back(mk(0, 1, 5'd5, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 0, 0, 2'd3, RD, 2'd0, 2'd0));
    tbl.push_back(mk(0, 1, 5'd5, 5'd0, 1, 1, 5'd5, 0, 5'd0, 0, 0, 0, 2'd3, RD, 2'd0, 2'd0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Redirect re-asserted on last flush cycle restarts the count
    tbl.push_back(idle(1'b0, 1'b1, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b1, 1'b0, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Redirect beats busy; busy beats the REDIRECT count-down
    tbl.push_back(idle(1'b0, 1'b1, 1'b1, 2'd0, H0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b1, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd2, MW));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Reset during REDIRECT, during MEM_WAIT, and reset beating redirect
    tbl.push_back(idle(1'b0, 1'b1, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b1, 1'b0, 1'b0, 2'd3, RD));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b1, 2'd0, H0));
    tbl.push_back(idle(1'b1, 1'b0, 1'b1, 2'd2, MW));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b1, 1'b1, 1'b0, 2'd0, H0));
    tbl.push_back(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Hand-written: a load to x0 is never a hazard
    drive(mk(0, 1, 5'd0, 5'd0, 0, 1, 5'd0, 0, 5'd0, 0, 0, 0, 2'd0, H0, 2'd0, 2'd0));
    drive(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));
    // Hand-written: load-use on rs2, then WB forward on rs2 after the bubble
    drive(mk(0, 1, 5'd3, 5'd8, 1, 1, 5'd8, 0, 5'd0, 0, 0, 0, 2'd0, H0, 2'd0, 2'd0));
    drive(mk(0, 1, 5'd3, 5'd8, 0, 0, 5'd0, 1, 5'd8, 0, 0, 0, 2'd1, LS, 2'd0, 2'd2));
    drive(mk(0, 1, 5'd3, 5'd8, 0, 0, 5'd0, 1, 5'd8, 0, 0, 0, 2'd0, H0, 2'd0, 2'd2));
    // Hand-written: lsu_done releases MEM_WAIT even while busy is still high
    drive(idle(1'b0, 1'b0, 1'b1, 2'd0, H0));
    drive(mk(0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 2'd2, MW, 2'd0, 2'd0));
    drive(idle(1'b0, 1'b0, 1'b0, 2'd0, H0));

    @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
